abs_arbiter: RTL and testbench

Round-robin arbiter that time-shares a single absolute-value operator among `NUM_REQ` requesters. Each granted sample is converted from 2's complement to unsigned magnitude and placed in a one-entry output buffer with a valid/ready handshake and a requester tag. It sits between multiple signal-conditioning channels and a downstream magnitude consumer such as a peak or envelope stage, replacing per-channel `abs` instances.

---
 rtl/abs_arbiter.sv | 141 ++++++++++++++
 tb/tb_abs_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/abs_arbiter.sv
// Round-robin arbiter sharing one abs() operator across NUM_REQ requesters into a one-entry valid/ready buffer.
// Define ABS_ARBITER_SAT_EN to saturate the most-negative input code and flag it on sat_o.
module abs_arbiter #(
    parameter  int unsigned DATA_WIDTH = 14,
    parameter  int unsigned NUM_REQ    = 4,
    localparam int unsigned ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
    output logic [NUM_REQ-1:0]            ack_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [DATA_WIDTH-2:0]         data_o,
    output logic [ID_W-1:0]               id_o,
    output logic                          sat_o
);

    localparam int unsigned MAG_W = DATA_WIDTH - 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ID_W-1:0]       r_last_grant;
    logic [MAG_W-1:0]      r_data;
    logic [ID_W-1:0]       r_id;

    logic                  w_slot_free;
    logic                  w_grant;
    logic                  w_found;
    logic [ID_W-1:0]       w_idx;
    logic [ID_W-1:0]       w_winner;
    logic [DATA_WIDTH-1:0] w_sample;
    logic [MAG_W-1:0]      w_mag_wrap;
    logic [MAG_W-1:0]      w_mag;

    // No grants while reset is held so ack_o stays low in reset.
    assign w_slot_free = rstn_i && ((r_state == ST_EMPTY) || ready_i);
    assign w_grant     = w_slot_free && w_found;

    // Rotating priority scan starting just above the last winner.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_idx = ID_W'((32'(r_last_grant) + 32'd1 + i) % NUM_REQ);
            if (!w_found && req_i[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_sample = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (w_winner == ID_W'(k)) begin
                w_sample = data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The low MAG_W bits of a two's-complement negation depend only on the low input bits.
    assign w_mag_wrap = w_sample[DATA_WIDTH-1] ? (~w_sample[MAG_W-1:0] + MAG_W'(1))
                                               : w_sample[MAG_W-1:0];

`ifdef ABS_ARBITER_SAT_EN
    logic r_sat;
    logic w_sat;

    assign w_sat   = (w_sample == {1'b1, {MAG_W{1'b0}}});
    assign w_mag   = w_sat ? {MAG_W{1'b1}} : w_mag_wrap;
    assign sat_o   = r_sat;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sat <= 1'b0;
        end else if (w_grant) begin
            r_sat <= w_sat;
        end
    end
`else
    assign w_mag   = w_mag_wrap;
    assign sat_o   = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_grant) begin
                    w_next_state = ST_FULL;
                end
            end
            ST_FULL: begin
                if (!w_grant && ready_i) begin
                    w_next_state = ST_EMPTY;
                end
            end
        endcase
    end

    always_comb begin
        ack_o   = '0;
        valid_o = (r_state == ST_FULL);
        if (w_grant) begin
            ack_o = NUM_REQ'(1) << w_winner;
        end
    end

    // Result buffer and priority pointer; reset restores requester 0 as first priority.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_data       <= '0;
            r_id         <= '0;
        end else if (w_grant) begin
            r_last_grant <= w_winner;
            r_data       <= w_mag;
            r_id         <= w_winner;
        end
    end

    assign data_o = r_data;
    assign id_o   = r_id;

endmodule

// File: tb/tb_abs_arbiter.sv
// Directed bench for abs_arbiter: a small arbitration model feeds a scoreboard of expected results.
// Honours ABS_ARBITER_SAT_EN the same way the design does.
module tb_abs_arbiter;

    localparam int unsigned DW = 14;
    localparam int unsigned NR = 4;

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-2:0] mag;
        logic          sat;
    } exp_t;

    logic            clk = 1'b0;
    logic            rstn_i;
    logic [NR-1:0]   req_i;
    logic [NR*DW-1:0] data_i;
    logic [NR-1:0]   ack_o;
    logic            valid_o;
    logic            ready_i;
    logic [DW-2:0]   data_o;
    logic [1:0]      id_o;
    logic            sat_o;

    int   checks   = 0;
    int   failures = 0;
    int   smp[NR];
    exp_t sb[$];
    bit   m_full;
    int   m_last;

    always #5 clk = ~clk;

    abs_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk_i   (clk),
        .rstn_i  (rstn_i),
        .req_i   (req_i),
        .data_i  (data_i),
        .ack_o   (ack_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .id_o    (id_o),
        .sat_o   (sat_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [NR-1:0] req, input logic rdy);
        req_i   = req;
        ready_i = rdy;
        for (int k = 0; k < int'(NR); k++) begin
            data_i[k*DW +: DW] = DW'(smp[k]);
        end
    endtask

    function automatic exp_t expect_of(input int k);
        exp_t e;
        int   mag;
        mag   = (smp[k] < 0) ? -smp[k] : smp[k];
        e.id  = 2'(k);
        e.sat = 1'b0;
        if (mag == 8192) begin
`ifdef ABS_ARBITER_SAT_EN
            mag   = 8191;
            e.sat = 1'b1;
`else
            mag   = 0;
`endif
        end
        e.mag = 13'(mag);
        return e;
    endfunction

    task automatic reset_model();
        m_full = 1'b0;
        m_last = int'(NR) - 1;
        sb.delete();
    endtask

    // Called at a negedge after inputs are driven: checks this cycle, then advances one clock.
    task automatic cycle();
        logic [NR-1:0] exp_ack;
        bit            grant;
        int            w;
        exp_t          e;
        #1;
        exp_ack = '0;
        grant   = 1'b0;
        w       = 0;
        if (!m_full || ready_i) begin
            for (int i = 0; i < int'(NR); i++) begin
                int idx;
                idx = (m_last + 1 + i) % int'(NR);
                if (!grant && req_i[idx]) begin
                    grant = 1'b1;
                    w     = idx;
                end
            end
        end
        if (grant) exp_ack = NR'(1 << w);
        check("ack", 32'(ack_o), 32'(exp_ack));
        check("valid", 32'(valid_o), 32'(m_full));
        if (m_full && sb.size() > 0) begin
            e = sb[0];
            check("sb_data", 32'(data_o), 32'(e.mag));
            check("sb_id", 32'(id_o), 32'(e.id));
            check("sb_sat", 32'(sat_o), 32'(e.sat));
            if (ready_i) void'(sb.pop_front());
        end
        if (grant) begin
            sb.push_back(expect_of(w));
            m_last = w;
            m_full = 1'b1;
        end else if (ready_i) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rstn_i  = 1'b0;
        req_i   = '0;
        ready_i = 1'b0;
        data_i  = '0;
        for (int k = 0; k < int'(NR); k++) smp[k] = 0;
        reset_model();

        // Reset values
        @(negedge clk);
        #1;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_id", 32'(id_o), 32'd0);
        check("rst_sat", 32'(sat_o), 32'd0);
        @(negedge clk);
        rstn_i = 1'b1;

        // Single request: -5 from requester 2
        smp[2] = -5;
        drive(4'b0100, 1'b1);
        cycle();
        drive(4'b0000, 1'b1);
        #1;
        check("t1_valid", 32'(valid_o), 32'd1);
        check("t1_data", 32'(data_o), 32'd5);
        check("t1_id", 32'(id_o), 32'd2);
        cycle();

        // Fairness from reset priority, data k = -(k+1)
        rstn_i = 1'b0;
        #1;
        reset_model();
        @(negedge clk);
        rstn_i = 1'b1;
        for (int k = 0; k < int'(NR); k++) smp[k] = -(k + 1);
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 1'b1);
            #1;
            check("fair_ack", 32'(ack_o), 32'(1 << (i % 4)));
            cycle();
        end
        drive(4'b0000, 1'b1);
        cycle();

        // Backpressure holding a result of 7
        smp[0] = 7;
        drive(4'b0001, 1'b1);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(4'b1111, 1'b0);
            #1;
            check("bp_ack", 32'(ack_o), 32'd0);
            check("bp_data", 32'(data_o), 32'd7);
            check("bp_id", 32'(id_o), 32'd0);
            cycle();
        end
        drive(4'b1111, 1'b1);
        #1;
        check("bp_regrant", 32'(ack_o), 32'b0010);
        cycle();
        drive(4'b0000, 1'b1);
        cycle();

        // Boundary input codes, back to back
        begin
            int vals[5];
            vals = '{8191, 0, -8192, -1, 1};
            for (int i = 0; i < 5; i++) begin
                smp[0] = vals[i];
                drive(4'b0001, 1'b1);
                cycle();
            end
        end
        drive(4'b0000, 1'b1);
        cycle();
        smp[0] = -8192;
        drive(4'b0001, 1'b1);
        cycle();
        drive(4'b0000, 1'b1);
        #1;
`ifdef ABS_ARBITER_SAT_EN
        check("min_data", 32'(data_o), 32'd8191);
        check("min_sat", 32'(sat_o), 32'd1);
`else
        check("min_data", 32'(data_o), 32'd0);
        check("min_sat", 32'(sat_o), 32'd0);
`endif
        cycle();

        // Reset while a result is buffered
        smp[1] = 3;
        drive(4'b0010, 1'b0);
        cycle();
        drive(4'b0000, 1'b0);
        #1;
        check("mr_pre_valid", 32'(valid_o), 32'd1);
        rstn_i = 1'b0;
        #1;
        check("mr_valid", 32'(valid_o), 32'd0);
        check("mr_data", 32'(data_o), 32'd0);
        check("mr_ack", 32'(ack_o), 32'd0);
        reset_model();
        @(negedge clk);
        rstn_i = 1'b1;
        smp[1] = 11;
        smp[3] = 12;
        drive(4'b1010, 1'b1);
        #1;
        check("mr_first", 32'(ack_o), 32'b0010);
        cycle();
        drive(4'b0000, 1'b1);
        cycle();

        // Withdrawn request while full and stalled
        smp[0] = 9;
        drive(4'b0001, 1'b0);
        cycle();
        drive(4'b1000, 1'b0);
        cycle();
        drive(4'b0000, 1'b0);
        cycle();
        drive(4'b0000, 1'b1);
        cycle();
        cycle();
        cycle();
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("end_valid", 32'(valid_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
